// File: rtl/hid_hub_if.sv
// MCU byte link between the host microcontroller and the HID hub.
//   data_in_strobe : one-cycle byte-valid
//   data_in_start  : qualifies the strobe, byte is a command
//   data_in        : byte from the MCU
//   data_out       : reply byte to the MCU
interface hid_hub_if;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output data_in_strobe,
    output data_in_start,
    output data_in,
    input  data_out
  );

  modport slave (
    input  data_in_strobe,
    input  data_in_start,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/hid_hub.sv
// HID hub: decodes MCU command packets into keyboard FIFO, mouse, joystick
// and status traffic, and raises an interrupt on local DB9 line changes.
// Ports:
//   clk, reset         : system clock, async active-high reset
//   mcu                : MCU byte link (hid_hub_if.slave)
//   db9_port           : asynchronous local joystick lines
//   irq / iack         : DB9-change interrupt and its acknowledge
//   kbd_data/valid/ready : first-word-fall-through keyboard FIFO read side
//   mouse_*            : mouse buttons, X, Y and update strobe
//   joy_*              : per-channel joystick bytes (channel n in [8n+7:8n]) and strobes
module hid_hub #(
  parameter int unsigned NUM_JOY   = 2,
  parameter int unsigned KBD_DEPTH = 8,
  parameter int unsigned DB9_W     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  hid_hub_if.slave               mcu,
  input  logic [DB9_W-1:0]       db9_port,
  output logic                   irq,
  input  logic                   iack,
  output logic [7:0]             kbd_data,
  output logic                   kbd_valid,
  input  logic                   kbd_ready,
  output logic [2:0]             mouse_btns,
  output logic [7:0]             mouse_x,
  output logic [7:0]             mouse_y,
  output logic                   mouse_strobe,
  output logic [8*NUM_JOY-1:0]   joy_dig,
  output logic [8*NUM_JOY-1:0]   joy_ax,
  output logic [8*NUM_JOY-1:0]   joy_ay,
  output logic [8*NUM_JOY-1:0]   joy_extra,
  output logic [NUM_JOY-1:0]     joy_strobe
);

  localparam int unsigned AW = $clog2(KBD_DEPTH);
  localparam int unsigned LW = AW + 1;

  // Packet state
  logic [7:0]          r_cmd;
  logic                r_cmd_vld;   // a command was received since reset
  logic [3:0]          r_idx;
  logic [7:0]          r_data_out;

  // Keyboard FIFO
  logic [7:0]          r_mem [KBD_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [LW-1:0]       r_level;
  logic                r_ovf;

  // Mouse / joystick
  logic [2:0]          r_mouse_btns;
  logic [7:0]          r_mouse_x;
  logic [7:0]          r_mouse_y;
  logic                r_mouse_stb;
  logic [7:0]          r_dev;
  logic [8*NUM_JOY-1:0] r_joy_dig;
  logic [8*NUM_JOY-1:0] r_joy_ax;
  logic [8*NUM_JOY-1:0] r_joy_ay;
  logic [8*NUM_JOY-1:0] r_joy_extra;
  logic [NUM_JOY-1:0]  r_joy_stb;

  // DB9 synchroniser and interrupt
  logic [DB9_W-1:0]    r_sync1;
  logic [DB9_W-1:0]    r_sync2;
  logic [DB9_W-1:0]    r_sync3;
  logic                r_irq;
  logic                r_irq_en;

  logic                w_byte;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_acc;
  logic                w_ovf_set;
  logic                w_ovf_clr;
  logic                w_chg;
  logic                w_irq_arm;
  logic [7:0]          w_reply;

  // Byte decode and reply selection
  always_comb begin
    w_byte    = mcu.data_in_strobe && !mcu.data_in_start && r_cmd_vld;
    w_push    = w_byte && (r_cmd == 8'd1);
    w_pop     = kbd_valid && kbd_ready;
    w_full    = (r_level == LW'(KBD_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    w_acc     = w_push && (!w_full || w_pop);
    w_ovf_set = w_push && w_full && !w_pop;
    w_ovf_clr = w_byte && (r_cmd == 8'd0) && (r_idx == 4'd2);
    w_chg     = (r_sync2 != r_sync3);
    w_irq_arm = w_byte && (r_cmd == 8'd4) && (r_idx == 4'd0);
    w_reply   = 8'h00;
    case (r_cmd)
      8'd0: begin
        case (r_idx)
          4'd0:    w_reply = 8'h02;
          4'd1:    w_reply = 8'(NUM_JOY);
          4'd2:    w_reply = {r_ovf, 2'b00, 5'(r_level)};
          default: w_reply = 8'h00;
        endcase
      end
      8'd4:    w_reply = 8'(r_sync2);
      default: w_reply = 8'h00;
    endcase
  end

  // Command latch, byte index and reply register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd      <= 8'h00;
      r_cmd_vld  <= 1'b0;
      r_idx      <= 4'd0;
      r_data_out <= 8'h00;
    end else if (mcu.data_in_strobe && mcu.data_in_start) begin
      r_cmd     <= mcu.data_in;
      r_cmd_vld <= 1'b1;
      r_idx     <= 4'd0;
    end else if (w_byte) begin
      r_data_out <= w_reply;
      if (r_idx != 4'd15) r_idx <= r_idx + 4'd1;
    end
  end

  // Keyboard FIFO storage, pointers, level and overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < KBD_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_mem[r_wptr] <= mcu.data_in;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_acc && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_acc && w_pop) r_level <= r_level - LW'(1);
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Mouse packet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mouse_btns <= 3'b000;
      r_mouse_x    <= 8'h00;
      r_mouse_y    <= 8'h00;
      r_mouse_stb  <= 1'b0;
    end else begin
      r_mouse_stb <= 1'b0;
      if (w_byte && (r_cmd == 8'd2)) begin
        case (r_idx)
          4'd0: r_mouse_btns <= mcu.data_in[2:0];
          4'd1: r_mouse_x    <= mcu.data_in;
          4'd2: begin
            r_mouse_y   <= mcu.data_in;
            r_mouse_stb <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Joystick packet; devices outside 0..NUM_JOY-1 match no channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dev       <= 8'h00;
      r_joy_dig   <= '0;
      r_joy_ax    <= '0;
      r_joy_ay    <= '0;
      r_joy_extra <= '0;
      r_joy_stb   <= '0;
    end else begin
      r_joy_stb <= '0;
      if (w_byte && (r_cmd == 8'd3)) begin
        if (r_idx == 4'd0) begin
          r_dev <= mcu.data_in;
        end else begin
          for (int unsigned n = 0; n < NUM_JOY; n++) begin
            if (r_dev == 8'(n)) begin
              case (r_idx)
                4'd1: r_joy_dig[8*n +: 8] <= mcu.data_in;
                4'd2: r_joy_ax[8*n +: 8]  <= mcu.data_in;
                4'd3: r_joy_ay[8*n +: 8]  <= mcu.data_in;
                4'd4: begin
                  r_joy_extra[8*n +: 8] <= mcu.data_in;
                  r_joy_stb[n]          <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

  // DB9 synchroniser; change between stages 2 and 3 fires a one-shot irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync3  <= '0;
      r_irq    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      r_sync1 <= db9_port;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (iack)                      r_irq <= 1'b0;
      else if (r_irq_en && w_chg)    r_irq <= 1'b1;
      if (w_irq_arm)                 r_irq_en <= 1'b1;
      else if (r_irq_en && w_chg)    r_irq_en <= 1'b0;
    end
  end

  assign mcu.data_out = r_data_out;
  assign kbd_data     = r_mem[r_rptr];
  assign kbd_valid    = (r_level != '0);
  assign mouse_btns   = r_mouse_btns;
  assign mouse_x      = r_mouse_x;
  assign mouse_y      = r_mouse_y;
  assign mouse_strobe = r_mouse_stb;
  assign joy_dig      = r_joy_dig;
  assign joy_ax       = r_joy_ax;
  assign joy_ay       = r_joy_ay;
  assign joy_extra    = r_joy_extra;
  assign joy_strobe   = r_joy_stb;
  assign irq          = r_irq;

endmodule
